sparse_weight_loader: RTL and testbench

//   Upstream feeder for sparse_core. Accepts a stream of compressed 2:4 sparse weights (value + index per beat),

---
 rtl/sparse_weight_loader_if.sv | 14 +
 rtl/sparse_weight_loader.sv | 165 ++++++++++++++++
 tb/tb_sparse_weight_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_weight_loader_if.sv
// Weight-beat stream into sparse_weight_loader: 16-bit beats with valid/ready/last.
`default_nettype none

interface sparse_weight_loader_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/sparse_weight_loader.sv
// Double-buffered loader that assembles 2:4 sparse weight beats into NUM_ROWS rows
// and promotes the shadow bank to the active bank on swap_req.
`default_nettype none

package sparse_weight_loader_pkg;
  typedef struct packed {
    logic signed [7:0] val_0;
    logic [1:0]        idx_0;
    logic signed [7:0] val_1;
    logic [1:0]        idx_1;
  } sparse_packet_t;
endpackage

module sparse_weight_loader
  import sparse_weight_loader_pkg::*;
#(
  parameter int NUM_ROWS = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  sparse_weight_loader_if.slave   s,
  input  wire logic               swap_req,
  output logic                    swap_ack,
  output sparse_packet_t          w_rows [NUM_ROWS],
  output logic                    weights_valid,
  output logic                    shadow_full,
  output logic                    err_idx,
  output logic                    err_frame,
  input  wire logic               err_clr
);

  localparam int BEATS = 2 * NUM_ROWS;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  sparse_packet_t   shadow [NUM_ROWS];

  logic       ready;
  logic       accept;
  logic       fill_beat;
  logic       last_slot;
  logic       do_swap;
  logic [1:0] prev_idx;
  logic       idx_bad;
  logic       frame_bad;
  logic       unused_bits;

  assign unused_bits = ^s.tdata[15:10];

  assign ready     = ((state == FILL) || (state == DRAIN)) && !rst;
  assign s.tready  = ready;
  assign accept    = s.tvalid && ready;
  assign fill_beat = accept && (state == FILL);
  assign last_slot = (beat_cnt == CNT_W'(BEATS - 1));
  assign do_swap   = (state == FULL) && shadow_full && swap_req;

  // idx_0 of the row the current odd beat completes, for the ascending-index check
  always_comb begin
    prev_idx = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (beat_cnt == CNT_W'(2 * r + 1)) begin
        prev_idx = shadow[r].idx_0;
      end
    end
  end

  assign idx_bad   = fill_beat && beat_cnt[0] && (s.tdata[9:8] <= prev_idx);
  assign frame_bad = fill_beat && (s.tlast != last_slot);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (accept && last_slot) begin
          state_nxt = s.tlast ? FULL : DRAIN;
        end
      end
      DRAIN: begin
        if (accept && s.tlast) begin
          state_nxt = FILL;
        end
      end
      FULL: begin
        if (do_swap) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      beat_cnt      <= '0;
      swap_ack      <= 1'b0;
      weights_valid <= 1'b0;
      shadow_full   <= 1'b0;
      err_idx       <= 1'b0;
      err_frame     <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        shadow[r] <= '0;
        w_rows[r] <= '0;
      end
    end else begin
      state    <= state_nxt;
      swap_ack <= do_swap;

      if (fill_beat) begin
        // any tlast or the final slot ends the frame; bad frames restart from slot 0
        if (s.tlast || last_slot) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
          if (beat_cnt == CNT_W'(2 * r)) begin
            shadow[r].val_0 <= s.tdata[7:0];
            shadow[r].idx_0 <= s.tdata[9:8];
          end
          if (beat_cnt == CNT_W'(2 * r + 1)) begin
            shadow[r].val_1 <= s.tdata[7:0];
            shadow[r].idx_1 <= s.tdata[9:8];
          end
        end
      end

      if (fill_beat && s.tlast && last_slot) begin
        shadow_full <= 1'b1;
      end else if (do_swap) begin
        shadow_full <= 1'b0;
      end

      if (do_swap) begin
        weights_valid <= 1'b1;
        for (int r = 0; r < NUM_ROWS; r++) begin
          w_rows[r] <= shadow[r];
        end
      end

      if (idx_bad) begin
        err_idx <= 1'b1;
      end else if (err_clr) begin
        err_idx <= 1'b0;
      end

      if (frame_bad) begin
        err_frame <= 1'b1;
      end else if (err_clr) begin
        err_frame <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sparse_weight_loader.sv
// Directed bench for sparse_weight_loader: frame loading, swap handshake, error flags, reset.
`default_nettype none

module tb_sparse_weight_loader;
  import sparse_weight_loader_pkg::*;

  localparam int NUM_ROWS = 4;
  localparam logic [15:0] IDX_STD = 16'hE4D8; // beats 0..7: 0,2,1,3,0,1,2,3
  localparam logic [15:0] IDX_BAD = 16'hE46C; // beats 0..7: 0,3,2,1,0,1,2,3

  logic clk;
  logic rst;
  logic swap_req;
  logic swap_ack;
  logic weights_valid;
  logic shadow_full;
  logic err_idx;
  logic err_frame;
  logic err_clr;
  sparse_packet_t w_rows [NUM_ROWS];

  int errors;
  int checks;

  sparse_weight_loader_if s_if ();

  sparse_weight_loader #(.NUM_ROWS(NUM_ROWS)) dut (
    .clk           (clk),
    .rst           (rst),
    .s             (s_if.slave),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .w_rows        (w_rows),
    .weights_valid (weights_valid),
    .shadow_full   (shadow_full),
    .err_idx       (err_idx),
    .err_frame     (err_frame),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic [1:0] idx, input logic last);
    int n;
    @(negedge clk);
    s_if.tdata  = {6'h2A, idx, v};
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
    n = 0;
    while (!s_if.tready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("tready_wait", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] base, input logic [15:0] idxs,
                            input int lo, input int hi, input int last_i);
    for (int i = lo; i <= hi; i++) begin
      send(base + 8'(i), idxs[2*(i%8) +: 2], i == last_i);
    end
  endtask

  task automatic swap(input string tag);
    @(negedge clk);
    swap_req = 1'b1;
    @(posedge clk);
    #1;
    swap_req = 1'b0;
    chk({tag, "_ack_hi"}, 32'(swap_ack), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_ack_lo"}, 32'(swap_ack), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    swap_req    = 1'b0;
    err_clr     = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(s_if.tready), 32'd0);
    chk("rst_wvalid", 32'(weights_valid), 32'd0);
    chk("rst_sfull", 32'(shadow_full), 32'd0);
    chk("rst_erridx", 32'(err_idx), 32'd0);
    chk("rst_errfrm", 32'(err_frame), 32'd0);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_row0", 32'(w_rows[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", 32'(s_if.tready), 32'd1);

    // frame 1: values 1..8
    send_range(8'h01, IDX_STD, 0, 7, 7);
    chk("f1_sfull", 32'(shadow_full), 32'd1);
    chk("f1_tready_full", 32'(s_if.tready), 32'd0);
    chk("f1_wvalid_pre", 32'(weights_valid), 32'd0);
    swap("f1");
    chk("f1_wvalid", 32'(weights_valid), 32'd1);
    chk("f1_sfull_clr", 32'(shadow_full), 32'd0);
    chk("f1_r0_val0", 32'($unsigned(w_rows[0].val_0)), 32'h01);
    chk("f1_r0_val1", 32'($unsigned(w_rows[0].val_1)), 32'h02);
    chk("f1_r0_idx0", 32'(w_rows[0].idx_0), 32'd0);
    chk("f1_r0_idx1", 32'(w_rows[0].idx_1), 32'd2);
    chk("f1_r3_val0", 32'($unsigned(w_rows[3].val_0)), 32'h07);
    chk("f1_r3_val1", 32'($unsigned(w_rows[3].val_1)), 32'h08);
    chk("f1_r3_idx0", 32'(w_rows[3].idx_0), 32'd2);
    chk("f1_r3_idx1", 32'(w_rows[3].idx_1), 32'd3);
    chk("f1_erridx", 32'(err_idx), 32'd0);
    chk("f1_errfrm", 32'(err_frame), 32'd0);

    // frame 2 loads behind the active bank; negative values pass unmodified
    send_range(8'hF9, IDX_STD, 0, 7, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("f2_tready_held", 32'(s_if.tready), 32'd0);
    chk("f2_sfull", 32'(shadow_full), 32'd1);
    chk("f2_active_kept", 32'($unsigned(w_rows[0].val_0)), 32'h01);
    swap("f2");
    chk("f2_r0_val0", 32'($unsigned(w_rows[0].val_0)), 32'hF9);
    chk("f2_r2_val1", 32'($unsigned(w_rows[2].val_1)), 32'hFE);
    chk("f2_r3_val1", 32'($unsigned(w_rows[3].val_1)), 32'h00);

    // early tlast on beat 5, then a stray swap_req outside FULL
    send_range(8'h21, IDX_STD, 0, 4, 4);
    chk("f3_errfrm", 32'(err_frame), 32'd1);
    chk("f3_sfull", 32'(shadow_full), 32'd0);
    chk("f3_tready", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    swap_req = 1'b1;
    @(posedge clk);
    #1;
    swap_req = 1'b0;
    chk("f3_noswap_ack", 32'(swap_ack), 32'd0);
    chk("f3_noswap_row", 32'($unsigned(w_rows[0].val_0)), 32'hF9);
    pulse_clr();
    chk("f3_errfrm_clr", 32'(err_frame), 32'd0);
    send_range(8'h31, IDX_STD, 0, 7, 7);
    chk("f3b_sfull", 32'(shadow_full), 32'd1);
    swap("f3b");
    chk("f3b_r1_val0", 32'($unsigned(w_rows[1].val_0)), 32'h33);
    chk("f3b_r1_idx0", 32'(w_rows[1].idx_0), 32'd1);
    chk("f3b_r1_val1", 32'($unsigned(w_rows[1].val_1)), 32'h34);
    chk("f3b_r1_idx1", 32'(w_rows[1].idx_1), 32'd3);
    chk("f3b_errfrm", 32'(err_frame), 32'd0);

    // 10-beat frame: error after beat 8, beats 9-10 drained
    send_range(8'h41, IDX_STD, 0, 7, -1);
    chk("f4_errfrm", 32'(err_frame), 32'd1);
    chk("f4_sfull", 32'(shadow_full), 32'd0);
    chk("f4_drain_tready", 32'(s_if.tready), 32'd1);
    send_range(8'h41, IDX_STD, 8, 9, 9);
    chk("f4_sfull_after", 32'(shadow_full), 32'd0);
    chk("f4_fill_tready", 32'(s_if.tready), 32'd1);
    pulse_clr();
    send_range(8'h51, IDX_STD, 0, 7, 7);
    chk("f4b_sfull", 32'(shadow_full), 32'd1);
    swap("f4b");
    chk("f4b_r0_val0", 32'($unsigned(w_rows[0].val_0)), 32'h51);
    chk("f4b_r3_val1", 32'($unsigned(w_rows[3].val_1)), 32'h58);
    chk("f4b_errfrm", 32'(err_frame), 32'd0);

    // row 1 indices 2 then 1; err_clr in the same cycle loses to the new error
    send_range(8'h61, IDX_BAD, 0, 2, -1);
    chk("f5_erridx_pre", 32'(err_idx), 32'd0);
    err_clr = 1'b1;
    send_range(8'h61, IDX_BAD, 3, 3, -1);
    err_clr = 1'b0;
    chk("f5_erridx", 32'(err_idx), 32'd1);
    send_range(8'h61, IDX_BAD, 4, 7, 7);
    swap("f5");
    chk("f5_r1_val0", 32'($unsigned(w_rows[1].val_0)), 32'h63);
    chk("f5_r1_idx0", 32'(w_rows[1].idx_0), 32'd2);
    chk("f5_r1_val1", 32'($unsigned(w_rows[1].val_1)), 32'h64);
    chk("f5_r1_idx1", 32'(w_rows[1].idx_1), 32'd1);
    chk("f5_erridx_held", 32'(err_idx), 32'd1);
    pulse_clr();
    chk("f5_erridx_clr", 32'(err_idx), 32'd0);

    // reset after 4 beats drops the partial frame and clears the active bank
    send_range(8'h71, IDX_STD, 0, 3, -1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("f6_rst_tready", 32'(s_if.tready), 32'd0);
    rst = 1'b0;
    #1;
    chk("f6_wvalid", 32'(weights_valid), 32'd0);
    chk("f6_row0_clr", 32'(w_rows[0]), 32'd0);
    chk("f6_sfull", 32'(shadow_full), 32'd0);
    send_range(8'h91, IDX_STD, 0, 7, 7);
    chk("f6b_sfull", 32'(shadow_full), 32'd1);
    swap("f6b");
    chk("f6b_wvalid", 32'(weights_valid), 32'd1);
    chk("f6b_r0_val0", 32'($unsigned(w_rows[0].val_0)), 32'h91);
    chk("f6b_r1_val1", 32'($unsigned(w_rows[1].val_1)), 32'h94);
    chk("f6b_r1_idx1", 32'(w_rows[1].idx_1), 32'd3);
    chk("f6b_r3_val1", 32'($unsigned(w_rows[3].val_1)), 32'h98);
    chk("f6b_errfrm", 32'(err_frame), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
